elevator_request_scheduler: RTL and testbench
=============================================

ELEVATOR_REQUEST_SCHEDULER -- requirements
Module: elevator_request_scheduler

Interface
REQ-001 SHALL have parameter NUM_FLOORS, default 8, number of serviced floors (2..16).
REQ-002 SHALL have parameter FLOOR_W, default $clog2(NUM_FLOORS), floor-index width.
REQ-003 SHALL have port clk  input  1  single clock; all logic on rising edge.
REQ-004 SHALL have port reset  input  1  synchronous, active-low reset.
REQ-005 SHALL have port req_valid  input  1  one-cycle pulse: floor button pressed (hall or car).
REQ-006 SHALL have port req_floor  input  FLOOR_W  requested floor index, sampled when req_valid=1.
REQ-007 SHALL have port cur_floor  input  FLOOR_W  car's current floor from the car model.
REQ-008 SHALL have port arrived  input  1  one-cycle pulse: car has stopped and opened doors at cur_floor.
REQ-009 SHALL have port queue_status  output  NUM_FLOORS  pending-request bitmap, bit i = floor i pending.
REQ-010 SHALL have port queue_empty  output  1  high when queue_status is all zero.
REQ-011 SHALL have port destination_floor  output  FLOOR_W  next floor the car shall travel to.
REQ-012 SHALL have port up_ndown  output  1  travel direction, 1=up, 0=down.
REQ-013 SHALL have port req_err  output  1  one-cycle pulse: req_floor >= NUM_FLOORS, request discarded.

Function
REQ-014 SHALL set queue_status[req_floor] on the cycle after a valid in-range req_valid; duplicate requests are idempotent.
REQ-015 SHALL clear queue_status[cur_floor] on the cycle after arrived=1.
REQ-016 SHALL, when req_valid and arrived coincide with req_floor==cur_floor, leave that bit clear (request deemed served).
REQ-017 SHALL, when req_valid and arrived coincide on different floors, apply both set and clear.
REQ-018 SHALL pulse req_err for exactly one cycle, one cycle after an out-of-range request, without altering queue_status.
REQ-019 SHALL run a direction FSM with states IDLE, UP, DOWN, evaluated every cycle on the registered queue_status.
REQ-020 IDLE: no pending -> stay; pending above cur_floor -> UP; else pending below -> DOWN; only cur_floor pending -> stay IDLE, destination_floor=cur_floor.
REQ-021 UP: destination_floor = lowest pending floor > cur_floor; none above but any below -> DOWN; none pending except cur_floor or empty -> IDLE.
REQ-022 DOWN: destination_floor = highest pending floor < cur_floor; none below but any above -> UP; otherwise IDLE.
REQ-023 up_ndown SHALL be 1 in UP, 0 in DOWN, and hold its last value in IDLE.
REQ-024 destination_floor, up_ndown and queue_empty SHALL be registered, updating one cycle after the queue_status change that causes them.
REQ-025 destination_floor SHALL hold its previous value whenever queue_empty=1.
REQ-026 A newly pending floor between cur_floor and current destination in the travel direction SHALL replace destination_floor (pick-up on the way).
REQ-027 A pending bit at cur_floor SHALL never be selected as destination while in UP or DOWN; it is served only via arrived.

Reset
REQ-028 SHALL, while reset=0 at a clock edge, clear queue_status, force queue_empty=1, destination_floor=0, up_ndown=1, req_err=0, FSM=IDLE.
REQ-029 SHALL discard req_valid and arrived presented in any cycle with reset=0, including mid-travel.

Structure
REQ-030 SHALL take NUM_FLOORS default, FLOOR_W and the dir_t enum (IDLE, UP, DOWN) from shared package elevator_pkg, also used by the car model.
REQ-031 SHALL instantiate one sub-module floor_priority_finder (combinational: given bitmap and cur_floor, returns nearest-above and nearest-below floors with found flags).

Verification
REQ-032 Reset, cur_floor=0, request floor 5 -> queue_status=0x20 next cycle, then up_ndown=1, destination_floor=5, queue_empty=0.
REQ-033 cur_floor=2 in UP to 6, request floor 4 -> destination_floor becomes 4; arrived at 4 -> destination_floor returns to 6.
REQ-034 cur_floor=6 in UP, pending only {1,3} -> DOWN, up_ndown=0, destination_floor=3.
REQ-035 req_floor=3 with arrived at cur_floor=3 same cycle -> bit 3 stays 0; req_floor=9 (NUM_FLOORS=8) -> req_err one-cycle pulse, queue unchanged.
REQ-036 Pending {2,7}, assert reset=0 one cycle -> queue_status=0, queue_empty=1, destination_floor=0, up_ndown=1, FSM IDLE.

Source files
------------

// File: rtl/elevator_pkg.sv
// -----------------------------------------------------------------------------
// elevator_pkg
// Shared definitions for the elevator request scheduler and the car model:
// default floor count, floor-index width and the travel-direction enum.
// -----------------------------------------------------------------------------
package elevator_pkg;

   localparam int DEFAULT_NUM_FLOORS = 8;
   localparam int DEFAULT_FLOOR_W    = $clog2(DEFAULT_NUM_FLOORS);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      UP   = 2'd1,
      DOWN = 2'd2
   } dir_t;

endpackage

// File: rtl/elevator_request_scheduler_floor_priority_finder.sv
// -----------------------------------------------------------------------------
// floor_priority_finder
// Combinational search of the pending-request bitmap relative to the car.
// Ports:
//   pending      in  NUM_FLOORS  pending-request bitmap, bit i = floor i
//   cur_floor    in  FLOOR_W     car's current floor
//   above_found  out 1           some floor strictly above cur_floor is pending
//   above_floor  out FLOOR_W     lowest pending floor strictly above cur_floor
//   below_found  out 1           some floor strictly below cur_floor is pending
//   below_floor  out FLOOR_W     highest pending floor strictly below cur_floor
// The floor at cur_floor itself is never reported; it is served by arrival.
// -----------------------------------------------------------------------------
import elevator_pkg::*;

module floor_priority_finder #(
   parameter int NUM_FLOORS = DEFAULT_NUM_FLOORS,
   parameter int FLOOR_W    = $clog2(NUM_FLOORS)
) (
   input  logic [NUM_FLOORS-1:0] pending,
   input  logic [FLOOR_W-1:0]    cur_floor,
   output logic                  above_found,
   output logic [FLOOR_W-1:0]    above_floor,
   output logic                  below_found,
   output logic [FLOOR_W-1:0]    below_floor
);

   // Nearest pending floor above the car. Scanning from the top floor down
   // means the last hit written is the lowest floor above cur_floor.
   always_comb begin
      above_found = 1'b0;
      above_floor = '0;
      for (int i = NUM_FLOORS - 1; i >= 0; i--) begin
         if (pending[i] && (FLOOR_W'(i) > cur_floor)) begin
            above_found = 1'b1;
            above_floor = FLOOR_W'(i);
         end
      end
   end

   // Nearest pending floor below the car. Scanning from floor 0 upward
   // means the last hit written is the highest floor below cur_floor.
   always_comb begin
      below_found = 1'b0;
      below_floor = '0;
      for (int i = 0; i < NUM_FLOORS; i++) begin
         if (pending[i] && (FLOOR_W'(i) < cur_floor)) begin
            below_found = 1'b1;
            below_floor = FLOOR_W'(i);
         end
      end
   end

endmodule

// File: rtl/elevator_request_scheduler.sv
// -----------------------------------------------------------------------------
// elevator_request_scheduler
// Keeps a bitmap of pending floor requests and drives a direction FSM
// (IDLE/UP/DOWN) that tells the car where to go next.
// Ports:
//   clk                in  1           single clock, rising edge
//   reset              in  1           synchronous, active-low reset
//   req_valid          in  1           one-cycle pulse, floor button pressed
//   req_floor          in  FLOOR_W     requested floor, sampled with req_valid
//   cur_floor          in  FLOOR_W     car's current floor
//   arrived            in  1           one-cycle pulse, car stopped at cur_floor
//   queue_status       out NUM_FLOORS  pending-request bitmap
//   queue_empty        out 1           registered "no requests pending"
//   destination_floor  out FLOOR_W     next floor the car travels to
//   up_ndown           out 1           travel direction, 1=up 0=down
//   req_err            out 1           one-cycle pulse, out-of-range request
// -----------------------------------------------------------------------------
import elevator_pkg::*;

module elevator_request_scheduler #(
   parameter int NUM_FLOORS = DEFAULT_NUM_FLOORS,
   parameter int FLOOR_W    = $clog2(NUM_FLOORS)
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  req_valid,
   input  logic [FLOOR_W-1:0]    req_floor,
   input  logic [FLOOR_W-1:0]    cur_floor,
   input  logic                  arrived,
   output logic [NUM_FLOORS-1:0] queue_status,
   output logic                  queue_empty,
   output logic [FLOOR_W-1:0]    destination_floor,
   output logic                  up_ndown,
   output logic                  req_err
);

   localparam logic [FLOOR_W:0] FLOOR_LIMIT = (FLOOR_W + 1)'(NUM_FLOORS);

   dir_t                  state;
   logic                  req_in_range;
   logic [NUM_FLOORS-1:0] set_mask;
   logic [NUM_FLOORS-1:0] clr_mask;
   logic                  cur_pending;
   logic                  above_found;
   logic [FLOOR_W-1:0]    above_floor;
   logic                  below_found;
   logic [FLOOR_W-1:0]    below_floor;

   assign req_in_range = ({1'b0, req_floor} < FLOOR_LIMIT);

   // Decode the request and arrival into one-hot set/clear masks. Any
   // out-of-range floor simply matches no bit, so it cannot touch the queue.
   always_comb begin
      set_mask    = '0;
      clr_mask    = '0;
      cur_pending = 1'b0;
      for (int i = 0; i < NUM_FLOORS; i++) begin
         set_mask[i] = req_valid && req_in_range && (req_floor == FLOOR_W'(i));
         clr_mask[i] = arrived && (cur_floor == FLOOR_W'(i));
         cur_pending = cur_pending | (queue_status[i] && (cur_floor == FLOOR_W'(i)));
      end
   end

   // Pending-request bitmap. The clear is applied after the set so that a
   // button press at the floor where the car is arriving counts as served.
   // The error pulse is registered alongside so it lands one cycle after
   // the offending request.
   always_ff @(posedge clk) begin
      if (!reset) begin
         queue_status <= '0;
         req_err      <= 1'b0;
      end else begin
         queue_status <= (queue_status | set_mask) & ~clr_mask;
         req_err      <= req_valid && !req_in_range;
      end
   end

   floor_priority_finder #(
      .NUM_FLOORS (NUM_FLOORS),
      .FLOOR_W    (FLOOR_W)
   ) u_finder (
      .pending     (queue_status),
      .cur_floor   (cur_floor),
      .above_found (above_found),
      .above_floor (above_floor),
      .below_found (below_found),
      .below_floor (below_floor)
   );

   // Direction FSM working on the registered bitmap, so every output here
   // trails the bitmap change by one cycle. The car keeps its direction as
   // long as work remains ahead and only turns around when nothing is left
   // that way; a newly pending floor closer than the current target is
   // picked up automatically because the finder always returns the nearest.
   // A request at the car's own floor is only ever chosen while IDLE, and
   // destination/direction simply hold whenever nothing else qualifies.
   always_ff @(posedge clk) begin
      if (!reset) begin
         state             <= IDLE;
         destination_floor <= '0;
         up_ndown          <= 1'b1;
         queue_empty       <= 1'b1;
      end else begin
         queue_empty <= (queue_status == '0);
         case (state)
            IDLE: begin
               if (above_found) begin
                  state             <= UP;
                  destination_floor <= above_floor;
                  up_ndown          <= 1'b1;
               end else if (below_found) begin
                  state             <= DOWN;
                  destination_floor <= below_floor;
                  up_ndown          <= 1'b0;
               end else if (cur_pending) begin
                  destination_floor <= cur_floor;
               end
            end
            UP: begin
               if (above_found) begin
                  destination_floor <= above_floor;
                  up_ndown          <= 1'b1;
               end else if (below_found) begin
                  state             <= DOWN;
                  destination_floor <= below_floor;
                  up_ndown          <= 1'b0;
               end else begin
                  state <= IDLE;
               end
            end
            DOWN: begin
               if (below_found) begin
                  destination_floor <= below_floor;
                  up_ndown          <= 1'b0;
               end else if (above_found) begin
                  state             <= UP;
                  destination_floor <= above_floor;
                  up_ndown          <= 1'b1;
               end else begin
                  state <= IDLE;
               end
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_elevator_request_scheduler.sv
// -----------------------------------------------------------------------------
// tb_elevator_request_scheduler
// Scenario-driven bench. Each stimulus cycle pushes the outputs expected just
// after that clock edge into a scoreboard queue; the observed outputs are
// captured #1 after the edge and each scenario task pops and compares them.
// Output snapshots are packed as {queue_status, queue_empty, destination_floor,
// up_ndown, req_err}. The DUT runs with FLOOR_W=4 so that floor 9 is
// representable and can exercise the out-of-range path.
// -----------------------------------------------------------------------------
module tb_elevator_request_scheduler;

   localparam int NF = 8;
   localparam int FW = 4;

   logic          clk = 1'b0;
   logic          reset;
   logic          req_valid;
   logic [FW-1:0] req_floor;
   logic [FW-1:0] cur_floor;
   logic          arrived;
   logic [NF-1:0] queue_status;
   logic          queue_empty;
   logic [FW-1:0] destination_floor;
   logic          up_ndown;
   logic          req_err;

   typedef struct {
      string       name;
      logic [14:0] val;
   } exp_t;

   exp_t        exp_q[$];
   logic [14:0] obs_q[$];
   int          checks   = 0;
   int          failures = 0;

   elevator_request_scheduler #(
      .NUM_FLOORS (NF),
      .FLOOR_W    (FW)
   ) dut (
      .clk               (clk),
      .reset             (reset),
      .req_valid         (req_valid),
      .req_floor         (req_floor),
      .cur_floor         (cur_floor),
      .arrived           (arrived),
      .queue_status      (queue_status),
      .queue_empty       (queue_empty),
      .destination_floor (destination_floor),
      .up_ndown          (up_ndown),
      .req_err           (req_err)
   );

   // Free-running clock, 10 time units per period.
   always #5 clk = ~clk;

   function automatic logic [14:0] ev(input logic [7:0] qs, input logic empty,
                                      input logic [3:0] dest, input logic up,
                                      input logic err);
      return {qs, empty, dest, up, err};
   endfunction

   // Drive one cycle of inputs, queue the expected post-edge outputs, then
   // sample the DUT #1 after the edge and drop the pulses again.
   task automatic applyStimulus(input string nm, input logic rst, input logic v,
                                input logic [3:0] rf, input logic [3:0] cf,
                                input logic arr, input logic [14:0] expv);
      exp_t e;
      reset     = rst;
      req_valid = v;
      req_floor = rf;
      cur_floor = cf;
      arrived   = arr;
      e.name    = nm;
      e.val     = expv;
      exp_q.push_back(e);
      @(posedge clk);
      #1;
      obs_q.push_back({queue_status, queue_empty, destination_floor, up_ndown, req_err});
      req_valid = 1'b0;
      arrived   = 1'b0;
   endtask

   task automatic test_reset;
      exp_t        e;
      logic [14:0] o;
      applyStimulus("reset_hold0", 0, 1, 5, 0, 1, ev(8'h00, 1, 0, 1, 0));
      applyStimulus("reset_hold1", 0, 1, 3, 3, 1, ev(8'h00, 1, 0, 1, 0));
      applyStimulus("reset_idle",  1, 0, 0, 0, 0, ev(8'h00, 1, 0, 1, 0));
      while (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         o = obs_q.pop_front();
         checks++;
         if (o !== e.val) begin
            failures++;
            $display("[TB] FAIL %s: observed qs=%h empty=%b dest=%0d up=%b err=%b, required qs=%h empty=%b dest=%0d up=%b err=%b",
                     e.name, o[14:7], o[6], o[5:2], o[1], o[0],
                     e.val[14:7], e.val[6], e.val[5:2], e.val[1], e.val[0]);
         end
      end
   endtask

   task automatic test_basic_request;
      exp_t        e;
      logic [14:0] o;
      applyStimulus("req5_queue",   1, 1, 5, 0, 0, ev(8'h20, 1, 0, 1, 0));
      applyStimulus("req5_dest",    1, 0, 0, 0, 0, ev(8'h20, 0, 5, 1, 0));
      applyStimulus("req5_hold",    1, 0, 0, 0, 0, ev(8'h20, 0, 5, 1, 0));
      applyStimulus("arrive5",      1, 0, 0, 5, 1, ev(8'h00, 0, 5, 1, 0));
      applyStimulus("arrive5_empty",1, 0, 0, 5, 0, ev(8'h00, 1, 5, 1, 0));
      while (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         o = obs_q.pop_front();
         checks++;
         if (o !== e.val) begin
            failures++;
            $display("[TB] FAIL %s: observed qs=%h empty=%b dest=%0d up=%b err=%b, required qs=%h empty=%b dest=%0d up=%b err=%b",
                     e.name, o[14:7], o[6], o[5:2], o[1], o[0],
                     e.val[14:7], e.val[6], e.val[5:2], e.val[1], e.val[0]);
         end
      end
   endtask

   task automatic test_pickup;
      exp_t        e;
      logic [14:0] o;
      applyStimulus("pick_req6",    1, 1, 6, 2, 0, ev(8'h40, 1, 5, 1, 0));
      applyStimulus("pick_up6",     1, 0, 0, 2, 0, ev(8'h40, 0, 6, 1, 0));
      applyStimulus("pick_req4",    1, 1, 4, 2, 0, ev(8'h50, 0, 6, 1, 0));
      applyStimulus("pick_dest4",   1, 0, 0, 2, 0, ev(8'h50, 0, 4, 1, 0));
      applyStimulus("pick_dup6",    1, 1, 6, 2, 0, ev(8'h50, 0, 4, 1, 0));
      applyStimulus("pick_arrive4", 1, 0, 0, 4, 1, ev(8'h40, 0, 6, 1, 0));
      applyStimulus("pick_back6",   1, 0, 0, 4, 0, ev(8'h40, 0, 6, 1, 0));
      while (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         o = obs_q.pop_front();
         checks++;
         if (o !== e.val) begin
            failures++;
            $display("[TB] FAIL %s: observed qs=%h empty=%b dest=%0d up=%b err=%b, required qs=%h empty=%b dest=%0d up=%b err=%b",
                     e.name, o[14:7], o[6], o[5:2], o[1], o[0],
                     e.val[14:7], e.val[6], e.val[5:2], e.val[1], e.val[0]);
         end
      end
   endtask

   task automatic test_reverse;
      exp_t        e;
      logic [14:0] o;
      applyStimulus("rev_req1",     1, 1, 1, 4, 0, ev(8'h42, 0, 6, 1, 0));
      applyStimulus("rev_req3",     1, 1, 3, 4, 0, ev(8'h4A, 0, 6, 1, 0));
      applyStimulus("rev_arrive6",  1, 0, 0, 6, 1, ev(8'h0A, 0, 3, 0, 0));
      applyStimulus("rev_down3",    1, 0, 0, 6, 0, ev(8'h0A, 0, 3, 0, 0));
      while (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         o = obs_q.pop_front();
         checks++;
         if (o !== e.val) begin
            failures++;
            $display("[TB] FAIL %s: observed qs=%h empty=%b dest=%0d up=%b err=%b, required qs=%h empty=%b dest=%0d up=%b err=%b",
                     e.name, o[14:7], o[6], o[5:2], o[1], o[0],
                     e.val[14:7], e.val[6], e.val[5:2], e.val[1], e.val[0]);
         end
      end
   endtask

   task automatic test_same_floor_and_err;
      exp_t        e;
      logic [14:0] o;
      applyStimulus("same_floor3",  1, 1, 3, 3, 1, ev(8'h02, 0, 1, 0, 0));
      applyStimulus("err_req9",     1, 1, 9, 3, 0, ev(8'h02, 0, 1, 0, 1));
      applyStimulus("err_gone",     1, 0, 0, 3, 0, ev(8'h02, 0, 1, 0, 0));
      applyStimulus("set7_clr1",    1, 1, 7, 1, 1, ev(8'h80, 0, 1, 0, 0));
      applyStimulus("idle_to_up7",  1, 0, 0, 1, 0, ev(8'h80, 0, 7, 1, 0));
      while (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         o = obs_q.pop_front();
         checks++;
         if (o !== e.val) begin
            failures++;
            $display("[TB] FAIL %s: observed qs=%h empty=%b dest=%0d up=%b err=%b, required qs=%h empty=%b dest=%0d up=%b err=%b",
                     e.name, o[14:7], o[6], o[5:2], o[1], o[0],
                     e.val[14:7], e.val[6], e.val[5:2], e.val[1], e.val[0]);
         end
      end
   endtask

   task automatic test_idle_at_cur;
      exp_t        e;
      logic [14:0] o;
      applyStimulus("cur_arrive7",  1, 0, 0, 7, 1, ev(8'h00, 0, 7, 1, 0));
      applyStimulus("cur_req4",     1, 1, 4, 4, 0, ev(8'h10, 1, 7, 1, 0));
      applyStimulus("cur_dest4",    1, 0, 0, 4, 0, ev(8'h10, 0, 4, 1, 0));
      applyStimulus("cur_served4",  1, 0, 0, 4, 1, ev(8'h00, 0, 4, 1, 0));
      applyStimulus("cur_empty",    1, 0, 0, 4, 0, ev(8'h00, 1, 4, 1, 0));
      while (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         o = obs_q.pop_front();
         checks++;
         if (o !== e.val) begin
            failures++;
            $display("[TB] FAIL %s: observed qs=%h empty=%b dest=%0d up=%b err=%b, required qs=%h empty=%b dest=%0d up=%b err=%b",
                     e.name, o[14:7], o[6], o[5:2], o[1], o[0],
                     e.val[14:7], e.val[6], e.val[5:2], e.val[1], e.val[0]);
         end
      end
   endtask

   task automatic test_back_to_back;
      exp_t        e;
      logic [14:0] o;
      applyStimulus("b2b_req2",     1, 1, 2, 4, 0, ev(8'h04, 1, 4, 1, 0));
      applyStimulus("b2b_req7",     1, 1, 7, 4, 0, ev(8'h84, 0, 2, 0, 0));
      applyStimulus("b2b_reset",    0, 1, 5, 4, 1, ev(8'h00, 1, 0, 1, 0));
      applyStimulus("b2b_after",    1, 0, 0, 4, 0, ev(8'h00, 1, 0, 1, 0));
      applyStimulus("b2b_req6",     1, 1, 6, 4, 0, ev(8'h40, 1, 0, 1, 0));
      applyStimulus("b2b_up6",      1, 0, 0, 4, 0, ev(8'h40, 0, 6, 1, 0));
      while (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         o = obs_q.pop_front();
         checks++;
         if (o !== e.val) begin
            failures++;
            $display("[TB] FAIL %s: observed qs=%h empty=%b dest=%0d up=%b err=%b, required qs=%h empty=%b dest=%0d up=%b err=%b",
                     e.name, o[14:7], o[6], o[5:2], o[1], o[0],
                     e.val[14:7], e.val[6], e.val[5:2], e.val[1], e.val[0]);
         end
      end
   endtask

   // Scenarios run back to back; each one starts from the state the previous
   // one leaves behind.
   initial begin
      reset     = 1'b0;
      req_valid = 1'b0;
      req_floor = '0;
      cur_floor = '0;
      arrived   = 1'b0;
      @(negedge clk);
      $display("[TB] starting elevator_request_scheduler scenarios");
      test_reset();
      test_basic_request();
      test_pickup();
      test_reverse();
      test_same_floor_and_err();
      test_idle_at_cur();
      test_back_to_back();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
